// File: rtl/calc_key_sequencer_pkg.sv
// Shared definitions for the calculator key sequencer: ALU op codes, state codes,
// switch bit positions and size defaults.
package calc_key_sequencer_pkg;

  localparam int MAX_DIGITS_DEF = 4;
  localparam int VW_DEF         = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  // swp: bit 1 is digit 0, bits 3..11 are digits 1..9
  localparam int KEY_DIGIT0 = 1;
  localparam int KEY_DIGIT1 = 3;
  localparam int KEY_DIGIT9 = 11;

  localparam int FN_NEG    = 7;
  localparam int FN_ADD    = 5;
  localparam int FN_SUB    = 4;
  localparam int FN_MUL    = 3;
  localparam int FN_DIV    = 2;
  localparam int FN_CLEAR  = 1;
  localparam int FN_EQUALS = 0;

  // Bits that produce key events; the rest never count toward the single-event rule.
  localparam logic [11:0] SWP_KEY_MASK = 12'hFFA;
  localparam logic [7:0]  SWD_KEY_MASK = 8'hBF;

  function automatic longint pow10(input int n);
    longint v;
    v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

endpackage

// File: rtl/calc_key_decode.sv
// Rising-edge detection on the key switches, rejection of multi-key cycles and
// decode into one registered digit / function strobe.
module calc_key_decode
  import calc_key_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_swp,
  input  logic [7:0]  i_swd,
  output logic        o_digit_vld,
  output logic [3:0]  o_digit,
  output logic        o_neg,
  output logic        o_op_vld,
  output logic [1:0]  o_op,
  output logic        o_clear,
  output logic        o_equals
);

  logic [11:0] r_swp_q;
  logic [7:0]  r_swd_q;
  logic        r_digit_vld;
  logic [3:0]  r_digit;
  logic        r_neg;
  logic        r_op_vld;
  logic [1:0]  r_op;
  logic        r_clear;
  logic        r_equals;

  logic [11:0] w_rise_p;
  logic [7:0]  w_rise_d;
  logic [19:0] w_evt;
  logic        w_single;
  logic [3:0]  w_digit;
  logic [1:0]  w_op;

  assign w_rise_p = i_swp & ~r_swp_q & SWP_KEY_MASK;
  assign w_rise_d = i_swd & ~r_swd_q & SWD_KEY_MASK;
  assign w_evt    = {w_rise_p, w_rise_d};
  // exactly one bit set: non-zero and clearing the lowest set bit leaves nothing
  assign w_single = (w_evt != '0) && ((w_evt & (w_evt - 20'd1)) == '0);

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    w_digit = '0;
    for (int i = KEY_DIGIT1; i <= KEY_DIGIT9; i++) begin
      if (w_rise_p[i]) w_digit = 4'(i - KEY_DIGIT1 + 1);
    end
    w_op = OP_ADD;
    if (w_rise_d[FN_SUB])      w_op = OP_SUB;
    else if (w_rise_d[FN_MUL]) w_op = OP_MUL;
    else if (w_rise_d[FN_DIV]) w_op = OP_DIV;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_swp_q     <= '0;
      r_swd_q     <= '0;
      r_digit_vld <= 1'b0;
      r_digit     <= '0;
      r_neg       <= 1'b0;
      r_op_vld    <= 1'b0;
      r_op        <= OP_ADD;
      r_clear     <= 1'b0;
      r_equals    <= 1'b0;
    end else begin
      r_swp_q     <= i_swp;
      r_swd_q     <= i_swd;
      r_digit_vld <= w_single & (|w_rise_p);
      r_digit     <= w_digit;
      r_neg       <= w_single & w_rise_d[FN_NEG];
      r_op_vld    <= w_single & (|w_rise_d[FN_ADD:FN_DIV]);
      r_op        <= w_op;
      r_clear     <= w_single & w_rise_d[FN_CLEAR];
      r_equals    <= w_single & w_rise_d[FN_EQUALS];
    end
  end

  assign o_digit_vld = r_digit_vld;
  assign o_digit     = r_digit;
  assign o_neg       = r_neg;
  assign o_op_vld    = r_op_vld;
  assign o_op        = r_op;
  assign o_clear     = r_clear;
  assign o_equals    = r_equals;

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: builds two signed decimal operands from key strokes,
// hands them to an external ALU and shows entry, result or error.
module calc_key_sequencer
  import calc_key_sequencer_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int VW         = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   swp,
  input  logic [7:0]    swd,
  output logic          alu_req,
  output logic [1:0]    alu_op,
  output logic [VW-1:0] alu_a,
  output logic [VW-1:0] alu_b,
  input  logic          alu_ack,
  input  logic [31:0]   alu_result,
  output logic [31:0]   disp_val,
  output logic [2:0]    state_o,
  output logic          err
);

  localparam int          CW      = $clog2(MAX_DIGITS + 1);
  localparam logic [31:0] MAX_MAG = 32'(pow10(MAX_DIGITS) - 64'sd1);

  typedef struct packed {
    logic [VW-1:0] mag;
    logic          neg;
    logic [CW-1:0] cnt;
  } operand_t;

  function automatic logic [VW-1:0] operand_val(input operand_t o);
    return o.neg ? (VW'(0) - o.mag) : o.mag;
  endfunction

  // mag*10 + digit as (mag<<3) + (mag<<1) + digit
  function automatic operand_t append_digit(input operand_t o, input logic [3:0] d);
    operand_t r;
    r = o;
    if (o.cnt < CW'(MAX_DIGITS)) begin
      r.mag = (o.mag << 3) + (o.mag << 1) + VW'(d);
      r.cnt = o.cnt + CW'(1);
    end
    return r;
  endfunction

  logic       w_digit_vld;
  logic [3:0] w_digit;
  logic       w_neg;
  logic       w_op_vld;
  logic [1:0] w_key_op;
  logic       w_clear;
  logic       w_equals;

  calc_key_decode u_decode (
    .clk        (clk),
    .rst        (rst),
    .i_swp      (swp),
    .i_swd      (swd),
    .o_digit_vld(w_digit_vld),
    .o_digit    (w_digit),
    .o_neg      (w_neg),
    .o_op_vld   (w_op_vld),
    .o_op       (w_key_op),
    .o_clear    (w_clear),
    .o_equals   (w_equals)
  );

  state_e        r_state, w_state_nxt;
  operand_t      r_a, w_a_nxt;
  operand_t      r_b, w_b_nxt;
  op_e           r_op, w_op_nxt;
  logic [31:0]   r_result, w_result_nxt;
  logic          r_err, w_err_nxt;
  logic [VW-1:0] r_alu_a, w_alu_a_nxt;
  logic [VW-1:0] r_alu_b, w_alu_b_nxt;

  logic [31:0]   w_res_abs;
  logic          w_res_fits;

  assign w_res_abs  = r_result[31] ? (32'd0 - r_result) : r_result;
  assign w_res_fits = (w_res_abs <= MAX_MAG);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ENTER_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_err    <= 1'b0;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_op     <= w_op_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
      r_alu_a  <= w_alu_a_nxt;
      r_alu_b  <= w_alu_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_op_nxt     = r_op;
    w_result_nxt = r_result;
    w_err_nxt    = r_err;
    w_alu_a_nxt  = r_alu_a;
    w_alu_b_nxt  = r_alu_b;

    if (r_state == ST_ISSUE) begin
      // keys are deaf while the ALU owns the operands
      if (alu_ack) begin
        w_result_nxt = alu_result;
        w_state_nxt  = ST_SHOW;
      end
    end else if (w_clear) begin
      w_state_nxt = ST_ENTER_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_op_nxt    = OP_ADD;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_ENTER_A: begin
          if (w_digit_vld) w_a_nxt = append_digit(r_a, w_digit);
          else if (w_neg)  w_a_nxt.neg = ~r_a.neg;
          else if (w_op_vld) begin
            w_op_nxt    = op_e'(w_key_op);
            w_b_nxt     = '0;
            w_state_nxt = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (w_digit_vld)   w_b_nxt = append_digit(r_b, w_digit);
          else if (w_neg)    w_b_nxt.neg = ~r_b.neg;
          else if (w_op_vld) w_op_nxt = op_e'(w_key_op);
          else if (w_equals) begin
            if (r_op == OP_DIV && r_b.mag == '0) begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = 1'b1;
            end else begin
              w_alu_a_nxt = operand_val(r_a);
              w_alu_b_nxt = operand_val(r_b);
              w_state_nxt = ST_ISSUE;
            end
          end
        end
        ST_SHOW: begin
          if (w_digit_vld) begin
            w_a_nxt     = '0;
            w_a_nxt.mag = VW'(w_digit);
            w_a_nxt.cnt = CW'(1);
            w_b_nxt     = '0;
            w_state_nxt = ST_ENTER_A;
          end else if (w_op_vld) begin
            if (w_res_fits) begin
              w_a_nxt.mag = VW'(w_res_abs);
              w_a_nxt.neg = r_result[31];
              w_a_nxt.cnt = CW'(MAX_DIGITS);
              w_b_nxt     = '0;
              w_op_nxt    = op_e'(w_key_op);
              w_state_nxt = ST_ENTER_B;
            end else begin
              w_state_nxt = ST_ERROR;
              w_err_nxt   = 1'b1;
            end
          end
        end
        ST_ERROR: ;
        default:  w_state_nxt = ST_ENTER_A;
      endcase
    end
  end

  always_comb begin
    disp_val = '0;
    case (r_state)
      ST_ENTER_A:          disp_val = 32'($signed(operand_val(r_a)));
      ST_ENTER_B, ST_ISSUE: disp_val = 32'($signed(operand_val(r_b)));
      ST_SHOW:             disp_val = r_result;
      default:             disp_val = '0;
    endcase
  end

  assign alu_req = (r_state == ST_ISSUE);
  assign alu_op  = r_op;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign state_o = r_state;
  assign err     = r_err;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Bench for calc_key_sequencer: directed scenarios plus random key strokes against
// a behavioural calculator model; an ALU responder checks every request.
module tb_calc_key_sequencer;

  localparam int S_A = 0, S_B = 1, S_ISSUE = 2, S_SHOW = 3, S_ERR = 4;
  localparam int K_DIG = 0, K_NEG = 1, K_OP = 2, K_CLR = 3, K_EQ = 4;
  localparam int MAXD = 4;
  localparam int LIMIT = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] swp = '0;
  logic [7:0]  swd = '0;
  logic        alu_req;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_ack = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] disp_val;
  logic [2:0]  state_o;
  logic        err;

  always #5 clk = ~clk;

  calc_key_sequencer #(.MAX_DIGITS(MAXD), .VW(16)) dut (
    .clk(clk), .rst(rst), .swp(swp), .swd(swd),
    .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ack(alu_ack), .alu_result(alu_result),
    .disp_val(disp_val), .state_o(state_o), .err(err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural calculator model ----------------
  typedef struct { int op; int a; int b; int res; } txn_t;
  txn_t exp_q[$];

  int m_state, m_op, m_res, issue_res;
  int m_a_mag, m_b_mag, m_a_cnt, m_b_cnt;
  bit m_a_neg, m_b_neg, m_err;
  int ack_delay = 1;

  function automatic int a_val();
    return m_a_neg ? -m_a_mag : m_a_mag;
  endfunction

  function automatic int b_val();
    return m_b_neg ? -m_b_mag : m_b_mag;
  endfunction

  function automatic int alu_fn(input int op, input int a, input int b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a * b;
      default: return a / b;
    endcase
  endfunction

  function automatic int disp_model();
    case (m_state)
      S_A:            return a_val();
      S_B, S_ISSUE:   return b_val();
      S_SHOW:         return m_res;
      default:        return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_A; m_op = 0; m_err = 0;
    m_a_mag = 0; m_a_neg = 0; m_a_cnt = 0;
    m_b_mag = 0; m_b_neg = 0; m_b_cnt = 0;
  endtask

  task automatic clear_b();
    m_b_mag = 0; m_b_neg = 0; m_b_cnt = 0;
  endtask

  task automatic model_event(input int kind, input int val);
    txn_t t;
    int mag;
    if (m_state == S_ISSUE) return;
    if (kind == K_CLR) begin model_reset(); return; end
    case (m_state)
      S_A: begin
        if (kind == K_DIG && m_a_cnt < MAXD) begin m_a_mag = m_a_mag * 10 + val; m_a_cnt++; end
        else if (kind == K_NEG) m_a_neg = !m_a_neg;
        else if (kind == K_OP) begin m_op = val; clear_b(); m_state = S_B; end
      end
      S_B: begin
        if (kind == K_DIG && m_b_cnt < MAXD) begin m_b_mag = m_b_mag * 10 + val; m_b_cnt++; end
        else if (kind == K_NEG) m_b_neg = !m_b_neg;
        else if (kind == K_OP) m_op = val;
        else if (kind == K_EQ) begin
          if (m_op == 3 && m_b_mag == 0) begin m_state = S_ERR; m_err = 1; end
          else begin
            t.op = m_op; t.a = a_val(); t.b = b_val(); t.res = alu_fn(m_op, t.a, t.b);
            exp_q.push_back(t);
            issue_res = t.res;
            m_state = S_ISSUE;
          end
        end
      end
      S_SHOW: begin
        if (kind == K_DIG) begin
          m_a_mag = val; m_a_neg = 0; m_a_cnt = 1; clear_b(); m_state = S_A;
        end else if (kind == K_OP) begin
          mag = (m_res < 0) ? -m_res : m_res;
          if (mag > LIMIT) begin m_state = S_ERR; m_err = 1; end
          else begin
            m_a_mag = mag; m_a_neg = (m_res < 0); m_a_cnt = MAXD;
            m_op = val; clear_b(); m_state = S_B;
          end
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_outputs(input string tag);
    check({tag, "_state"}, state_o, m_state);
    check({tag, "_disp"}, $signed(disp_val), disp_model());
    check({tag, "_err"}, err, m_err);
  endtask

  task automatic press(input logic [11:0] p, input logic [7:0] d, input int hold);
    @(negedge clk);
    swp = p; swd = d;
    repeat (hold) @(negedge clk);
    swp = '0; swd = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic key(input int kind, input int val = 0, input int hold = 2);
    logic [11:0] p;
    logic [7:0]  d;
    p = '0; d = '0;
    case (kind)
      K_DIG:   if (val == 0) p[1] = 1'b1; else p[val + 2] = 1'b1;
      K_NEG:   d[7] = 1'b1;
      K_OP:    d[5 - val] = 1'b1;
      K_CLR:   d[1] = 1'b1;
      default: d[0] = 1'b1;
    endcase
    model_event(kind, val);
    press(p, d, hold);
    if (m_state != S_ISSUE) check_outputs($sformatf("key%0d", kind));
  endtask

  task automatic wait_show();
    for (int i = 0; i < 200 && state_o != 3'd3; i++) @(negedge clk);
    check("show_reached", state_o, S_SHOW);
    m_state = S_SHOW;
    m_res   = issue_res;
    check_outputs("show");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  // ---------------- ALU responder / request monitor ----------------
  txn_t cur;
  bit   pending  = 0;
  bit   drop_chk = 0;
  int   wait_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      alu_ack = 1'b0;
      if (drop_chk) begin
        check("req_drop_after_ack", alu_req, 0);
        drop_chk = 0;
      end
      if (rst !== 1'b0 || alu_req !== 1'b1) begin
        pending = 0;
      end else begin
        if (!pending) begin
          if (exp_q.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL unexpected_req: alu_req=1 op=%0d a=%0d b=%0d, none expected",
                     alu_op, $signed(alu_a), $signed(alu_b));
            cur = '{0, 0, 0, 0};
          end else begin
            cur = exp_q.pop_front();
            check("alu_op", alu_op, cur.op);
            check("alu_a", $signed(alu_a), cur.a);
            check("alu_b", $signed(alu_b), cur.b);
          end
          pending  = 1;
          wait_cnt = ack_delay;
        end else begin
          check("alu_op_stable", alu_op, cur.op);
          check("alu_a_stable", $signed(alu_a), cur.a);
          check("alu_b_stable", $signed(alu_b), cur.b);
        end
        if (wait_cnt == 0) begin
          alu_ack    = 1'b1;
          alu_result = cur.res;
          pending    = 0;
          drop_chk   = 1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r, v;
    logic [11:0] p2;

    do_reset();
    check("rst_state", state_o, S_A);
    check("rst_disp", disp_val, 0);
    check("rst_err", err, 0);
    check("rst_req", alu_req, 0);
    check("rst_op", alu_op, 0);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);

    // 23 + (-456)
    ack_delay = 2;
    key(K_DIG, 2); key(K_DIG, 3); key(K_OP, 0); key(K_NEG);
    key(K_DIG, 4); key(K_DIG, 5); key(K_DIG, 6); key(K_EQ);
    wait_show();
    check("sum_disp", $signed(disp_val), -433);

    // fifth digit ignored
    key(K_CLR);
    for (int i = 1; i <= 5; i++) key(K_DIG, i);
    check("max_digits_disp", $signed(disp_val), 1234);

    // divide by zero
    key(K_CLR);
    key(K_DIG, 7); key(K_OP, 3); key(K_DIG, 0); key(K_EQ);
    check("div0_err", err, 1);
    check("div0_state", state_o, S_ERR);
    key(K_DIG, 5);
    key(K_CLR);
    check("div0_clear_err", err, 0);
    check("div0_clear_state", state_o, S_A);

    // simultaneous keys ignored, held key counted once
    press(12'hC00, 8'h00, 2);
    check_outputs("double");
    key(K_DIG, 9, 10);
    check("held_disp", $signed(disp_val), 9);

    // chain from result 12, then reset while requesting
    key(K_CLR);
    key(K_DIG, 6); key(K_OP, 2); key(K_DIG, 2); key(K_EQ);
    wait_show();
    check("chain_src_disp", $signed(disp_val), 12);
    ack_delay = 40;
    key(K_OP, 1); key(K_DIG, 5); key(K_EQ);
    check("issue_req", alu_req, 1);
    check("issue_a", $signed(alu_a), 12);
    check("issue_b", $signed(alu_b), 5);
    key(K_DIG, 7);
    key(K_CLR);
    check("issue_deaf_state", state_o, S_ISSUE);
    check("issue_deaf_disp", $signed(disp_val), 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_issue_req", alu_req, 0);
    check("rst_issue_state", state_o, S_A);
    rst = 1'b0;
    model_reset();
    exp_q.delete();

    // random key strokes
    for (int it = 0; it < 300; it++) begin
      ack_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 50)      key(K_DIG, $urandom_range(0, 9));
      else if (r < 58) key(K_NEG);
      else if (r < 73) key(K_OP, $urandom_range(0, 3));
      else if (r < 88) key(K_EQ);
      else if (r < 93) key(K_CLR);
      else begin
        v  = $urandom_range(3, 10);
        p2 = '0;
        p2[v] = 1'b1;
        p2[v + 1] = 1'b1;
        press(p2, 8'h00, 2);
        check_outputs("rand_double");
      end
      if (m_state == S_ISSUE) wait_show();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
